mb_mult_sched: RTL and testbench
================================

// Module: mb_mult_sched
// PURPOSE
//  Round-robin scheduler sharing one pipelined radix-8 Booth multiplier (mb16_top + pre_process_be)
//  among NREQ requesters. Issues at most one operand pair per cycle, precomputes tmy = 3*my,
//  tags each issue with its requester ID through a LAT-deep tag pipe and routes products back.
//  Provides a pause/drain FSM so software can quiesce the multiplier.
// PARAMETERS
//  WIDTH  16  operand/product width
//  NREQ   4   number of requesters (>=2)
//  LAT    3   clock edges from operand launch on mul_* to matching mul_product
// PORTS
//  CLK          in   1            clock, all state on posedge
//  RST          in   1            synchronous reset, active-high
//  req_valid    in   NREQ         requester i has an operand pair
//  req_mx       in   NREQ*WIDTH   multiplicand, slice i = [i*WIDTH +: WIDTH]
//  req_my       in   NREQ*WIDTH   multiplier, same slicing
//  req_ready    out  NREQ         one-hot grant; transfer when req_valid[i]&req_ready[i]
//  pause        in   1            request quiesce
//  pause_ack    out  1            FSM in HELD (no issue, pipe empty)
//  mul_mx       out  WIDTH        registered operand to pre_process_be
//  mul_my       out  WIDTH        registered operand to multiplier
//  mul_tmy      out  WIDTH+2      registered my+(my<<1)
//  mul_product  in   WIDTH        multiplier result, LAT edges after launch
//  rsp_valid    out  NREQ         one-hot, owner of rsp_product this cycle
//  rsp_product  out  WIDTH        registered product
//  inflight     out  $clog2(LAT+2) issues launched, product not yet returned
// BEHAVIOUR
//  Reset: all outputs 0; rr pointer=0; tag pipe valid bits cleared; FSM=RUN.
//  FSM: RUN -(pause)-> DRAIN -(inflight==0)-> HELD -(!pause)-> RUN; DRAIN -(!pause)-> RUN.
//   Grants only in RUN. pause_ack=1 only in HELD. pause and empty pipe same cycle: RUN->DRAIN->HELD.
//  Arbitration (comb): first i with req_valid[i] searching ptr, ptr+1, ... mod NREQ; req_ready one-hot
//   or 0. On transfer at edge k: ptr<=(grant+1)%NREQ; mul_mx/my/tmy <= operands; tag {1,id} enters
//   stage 0. No transfer: mul_* hold value, bubble (valid 0) enters stage 0.
//  Tag pipe: LAT stages. At edge k+LAT: rsp_product<=mul_product, rsp_valid<=onehot(id) if tag
//   valid else 0. rsp_valid is a 1-cycle pulse; no response backpressure.
//  Throughput 1 op/cycle; grant-to-rsp_valid = LAT edges after the transfer edge.
//  inflight: +1 on issue, -1 on return, both same edge -> unchanged; max LAT.
//  Arithmetic: product = (mx*my) mod 2^WIDTH as returned (not recomputed); mul_tmy exact in WIDTH+2.
//  req_valid dropped without ready: no effect. Non-granted requesters must hold operands.
//  RST mid-operation: tag pipe cleared, in-flight results discarded (no rsp_valid for them).
// TESTING
//  R0 only, mx=3 my=5 -> req_ready=0001 one cycle; rsp_valid=0001, rsp_product=15 LAT edges later.
//  All 4 valid 12 cycles -> grants 0,1,2,3,0,1,...; each rsp_valid owner matches issuer, 1/cycle.
//  mx=0xFFFF my=0xFFFF -> mul_tmy=0x2FFFD, rsp_product=0x0001.
//  pause mid-stream, 3 in flight -> no grants from next cycle; 3 rsp pulses; pause_ack after
//   inflight=0; drop pause -> RUN, grants resume at saved ptr.
//  RST high with 2 in flight -> no rsp_valid after; inflight=0, ptr=0, req_ready(R2 only)=0100.
//  R1,R3 valid, ptr=2 -> grant R3 then R1 (wrap-around).

Source files
------------

// File: rtl/mb_mult_sched.sv
// Round-robin front end for one shared pipelined Booth multiplier: arbitrates NREQ requesters,
// launches operands (with 3*my), tracks requester tags through the pipe and returns products.
module mb_mult_sched #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int LAT   = 3
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*WIDTH-1:0]     req_mx,
  input  logic [NREQ*WIDTH-1:0]     req_my,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      pause,
  output logic                      pause_ack,
  output logic [WIDTH-1:0]          mul_mx,
  output logic [WIDTH-1:0]          mul_my,
  output logic [WIDTH+1:0]          mul_tmy,
  input  logic [WIDTH-1:0]          mul_product,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [WIDTH-1:0]          rsp_product,
  output logic [$clog2(LAT+2)-1:0]  inflight
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(LAT+2);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HELD} state_t;

  state_t              r_state;
  logic                r_pause_ack;
  logic [IDW-1:0]      r_ptr;
  logic [WIDTH-1:0]    r_mul_mx;
  logic [WIDTH-1:0]    r_mul_my;
  logic [WIDTH+1:0]    r_mul_tmy;
  logic [LAT-1:0]      r_tag_v;
  logic [IDW-1:0]      r_tag_id [LAT];
  logic [NREQ-1:0]     r_rsp_valid;
  logic [WIDTH-1:0]    r_rsp_product;
  logic [CW-1:0]       r_inflight;

  logic                w_found;
  logic [IDW-1:0]      w_gnt_id;
  int unsigned         w_idx;
  logic                w_xfer;
  logic                w_ret;
  logic [WIDTH-1:0]    w_sel_mx;
  logic [WIDTH-1:0]    w_sel_my;
  logic [WIDTH+1:0]    w_tmy;

  // Search starts at the pointer and wraps, so the last winner has lowest priority next time.
  always_comb begin
    w_found  = 1'b0;
    w_gnt_id = '0;
    w_idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_found && req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_gnt_id = w_idx[IDW-1:0];
      end
    end
  end

  assign w_xfer    = w_found && (r_state == S_RUN);
  assign req_ready = w_xfer ? (NREQ'(1) << w_gnt_id) : '0;
  assign w_ret     = r_tag_v[LAT-1];

  assign w_sel_mx = req_mx[w_gnt_id*WIDTH +: WIDTH];
  assign w_sel_my = req_my[w_gnt_id*WIDTH +: WIDTH];
  assign w_tmy    = {2'b00, w_sel_my} + {1'b0, w_sel_my, 1'b0};

  // Leaving DRAIN on a dropped pause takes priority over completing the quiesce.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_RUN;
      r_pause_ack <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (pause) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!pause) begin
            r_state <= S_RUN;
          end else if (r_inflight == '0) begin
            r_state     <= S_HELD;
            r_pause_ack <= 1'b1;
          end
        end
        S_HELD: begin
          if (!pause) begin
            r_state     <= S_RUN;
            r_pause_ack <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_RUN;
          r_pause_ack <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ptr     <= '0;
      r_mul_mx  <= '0;
      r_mul_my  <= '0;
      r_mul_tmy <= '0;
    end else if (w_xfer) begin
      r_ptr     <= (w_gnt_id == IDW'(NREQ-1)) ? '0 : w_gnt_id + IDW'(1);
      r_mul_mx  <= w_sel_mx;
      r_mul_my  <= w_sel_my;
      r_mul_tmy <= w_tmy;
    end
  end

  // Tag pipe runs in lockstep with the multiplier; bubbles travel with valid=0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tag_v <= '0;
      for (int s = 0; s < LAT; s++) r_tag_id[s] <= '0;
    end else begin
      r_tag_v[0]  <= w_xfer;
      r_tag_id[0] <= w_gnt_id;
      for (int s = 1; s < LAT; s++) begin
        r_tag_v[s]  <= r_tag_v[s-1];
        r_tag_id[s] <= r_tag_id[s-1];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rsp_valid   <= '0;
      r_rsp_product <= '0;
    end else begin
      r_rsp_valid <= w_ret ? (NREQ'(1) << r_tag_id[LAT-1]) : '0;
      if (w_ret) r_rsp_product <= mul_product;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_inflight <= '0;
    end else begin
      case ({w_xfer, w_ret})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign pause_ack   = r_pause_ack;
  assign mul_mx      = r_mul_mx;
  assign mul_my      = r_mul_my;
  assign mul_tmy     = r_mul_tmy;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_product = r_rsp_product;
  assign inflight    = r_inflight;

endmodule

// File: tb/tb_mb_mult_sched.sv
// Bench for mb_mult_sched: a behavioural multiplier closes the loop; a scoreboard queue holds the
// owner, product and arrival cycle of every issue and is checked against each rsp_valid pulse.
module tb_mb_mult_sched;
  localparam int WIDTH = 16;
  localparam int NREQ  = 4;
  localparam int LAT   = 3;
  localparam int CW    = $clog2(LAT+2);

  logic                   CLK;
  logic                   RST;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*WIDTH-1:0]  req_mx;
  logic [NREQ*WIDTH-1:0]  req_my;
  logic [NREQ-1:0]        req_ready;
  logic                   pause;
  logic                   pause_ack;
  logic [WIDTH-1:0]       mul_mx;
  logic [WIDTH-1:0]       mul_my;
  logic [WIDTH+1:0]       mul_tmy;
  logic [WIDTH-1:0]       mul_product;
  logic [NREQ-1:0]        rsp_valid;
  logic [WIDTH-1:0]       rsp_product;
  logic [CW-1:0]          inflight;

  mb_mult_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .LAT(LAT)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_mx(req_mx), .req_my(req_my), .req_ready(req_ready),
    .pause(pause), .pause_ack(pause_ack),
    .mul_mx(mul_mx), .mul_my(mul_my), .mul_tmy(mul_tmy), .mul_product(mul_product),
    .rsp_valid(rsp_valid), .rsp_product(rsp_product), .inflight(inflight)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Multiplier model: operands launched at edge k give a product sampled at edge k+LAT.
  logic [WIDTH-1:0] mp [LAT-1];
  always @(posedge CLK) begin
    mp[0] <= WIDTH'(mul_mx * mul_my);
    for (int s = 1; s < LAT-1; s++) mp[s] <= mp[s-1];
  end
  assign mul_product = mp[LAT-2];

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int               id;
    logic [WIDTH-1:0] prod;
    int               at;
  } exp_t;

  exp_t             sb[$];
  int               gnt_log[$];
  int               n_assert = 0;
  int               n_fail = 0;
  int               rsp_count = 0;
  logic [WIDTH-1:0] last_rsp_prod;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Monitor, sampled on the falling edge.
  logic             pend_op = 1'b0;
  logic [WIDTH-1:0] pend_mx, pend_my;
  logic [WIDTH+1:0] pend_tmy;
  logic [NREQ-1:0]  m_xfer;
  int               m_id;
  exp_t             m_e;

  always @(negedge CLK) begin
    if (RST) begin
      sb.delete();
      pend_op = 1'b0;
    end else begin
      if (pend_op) begin
        check_val("mul_mx", mul_mx, pend_mx);
        check_val("mul_my", mul_my, pend_my);
        check_val("mul_tmy", mul_tmy, pend_tmy);
        pend_op = 1'b0;
      end
      if (rsp_valid != '0) begin
        rsp_count++;
        last_rsp_prod = rsp_product;
        $display("rsp owner=%b product=0x%h cycle=%0d", rsp_valid, rsp_product, cyc);
        if (sb.size() == 0) begin
          check_val("rsp_unexpected", rsp_valid, 0);
        end else begin
          m_e = sb.pop_front();
          check_val("rsp_owner", rsp_valid, 64'(1) << m_e.id);
          check_val("rsp_product", rsp_product, m_e.prod);
          check_val("rsp_cycle", cyc, m_e.at);
        end
      end else if (sb.size() != 0 && sb[0].at <= cyc) begin
        check_val("rsp_missing", rsp_valid, 64'(1) << sb[0].id);
        void'(sb.pop_front());
      end
      m_xfer = req_valid & req_ready;
      if (m_xfer != '0) begin
        m_id = 0;
        for (int i = 0; i < NREQ; i++) if (m_xfer[i]) m_id = i;
        pend_mx  = req_mx[m_id*WIDTH +: WIDTH];
        pend_my  = req_my[m_id*WIDTH +: WIDTH];
        pend_tmy = 18'(pend_my) * 18'd3;
        m_e.id   = m_id;
        m_e.prod = WIDTH'(pend_mx * pend_my);
        m_e.at   = cyc + 1 + LAT;
        sb.push_back(m_e);
        gnt_log.push_back(m_id);
        pend_op = 1'b1;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic set_op(input int i, input logic [WIDTH-1:0] mx, input logic [WIDTH-1:0] my);
    req_mx[i*WIDTH +: WIDTH] = mx;
    req_my[i*WIDTH +: WIDTH] = my;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    req_valid = '0;
    pause = 1'b0;
    step(2);
    RST = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    for (int i = 0; i < max_cyc && sb.size() != 0; i++) step(1);
    step(2);
    check_val("drain", sb.size(), 0);
  endtask

  int g, gs, n0;

  initial begin
    RST = 1'b1; req_valid = '0; pause = 1'b0; req_mx = '0; req_my = '0;
    step(3);
    check_val("rst_ready", req_ready, 0);
    check_val("rst_rsp_valid", rsp_valid, 0);
    check_val("rst_rsp_product", rsp_product, 0);
    check_val("rst_inflight", inflight, 0);
    check_val("rst_pause_ack", pause_ack, 0);
    check_val("rst_mul_tmy", mul_tmy, 0);
    RST = 1'b0;
    step(1);

    // Single request from R0.
    set_op(0, 16'd3, 16'd5);
    req_valid = 4'b0001;
    #1;
    check_val("t1_ready", req_ready, 4'b0001);
    step(1);
    req_valid = '0;
    check_val("t1_inflight", inflight, 1);
    wait_drain(20);
    check_val("t1_prod", last_rsp_prod, 15);

    // All four requesters continuously for 12 cycles.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 16'h1111 * (i + 1) + 16'd7, 16'h0203 + 16'(i * 77));
    gs = gnt_log.size();
    req_valid = 4'b1111;
    step(12);
    req_valid = '0;
    check_val("t2_count", gnt_log.size() - gs, 12);
    for (int i = 0; i < 12; i++) check_val("t2_grant", gnt_log[gs+i], i % NREQ);
    wait_drain(20);

    // Extreme operands.
    set_op(2, 16'hFFFF, 16'hFFFF);
    req_valid = 4'b0100;
    step(1);
    req_valid = '0;
    check_val("t3_tmy", mul_tmy, 18'h2FFFD);
    wait_drain(20);
    check_val("t3_prod", last_rsp_prod, 16'h0001);

    // Pause with a full pipe.
    do_reset();
    req_valid = 4'b1111;
    step(5);
    pause = 1'b1;
    step(1);
    g = gnt_log[gnt_log.size()-1];
    check_val("t4_inflight", inflight, 3);
    check_val("t4_no_grant", req_ready, 0);
    check_val("t4_ack_low", pause_ack, 0);
    n0 = rsp_count + ((rsp_valid != '0) ? 1 : 0);
    for (int i = 0; i < 20 && !pause_ack; i++) step(1);
    check_val("t4_ack", pause_ack, 1);
    check_val("t4_rsp_pulses", rsp_count - n0, 3);
    check_val("t4_inflight_0", inflight, 0);
    step(2);
    check_val("t4_held_no_grant", req_ready, 0);
    pause = 1'b0;
    step(1);
    check_val("t4_resume_ptr", req_ready, 4'(1 << ((g + 1) % NREQ)));
    check_val("t4_ack_drop", pause_ack, 0);
    req_valid = '0;
    wait_drain(20);

    // Pause on an empty pipe: RUN -> DRAIN -> HELD.
    pause = 1'b1;
    step(1);
    check_val("t4b_drain_ack", pause_ack, 0);
    step(1);
    check_val("t4b_held_ack", pause_ack, 1);
    pause = 1'b0;
    step(1);
    check_val("t4b_run_ack", pause_ack, 0);

    // Reset with two products in flight.
    do_reset();
    req_valid = 4'b0011;
    step(2);
    check_val("t5_inflight_2", inflight, 2);
    RST = 1'b1;
    req_valid = 4'b0100;
    step(1);
    RST = 1'b0;
    check_val("t5_inflight", inflight, 0);
    check_val("t5_ready", req_ready, 4'b0100);
    req_valid = '0;
    n0 = rsp_count;
    step(6);
    check_val("t5_no_rsp", rsp_count - n0, 0);

    // Wrap-around: pointer at 2 with R1 and R3 requesting.
    req_valid = 4'b0010;
    step(1);
    gs = gnt_log.size();
    req_valid = 4'b1010;
    step(2);
    req_valid = '0;
    check_val("t6_first", gnt_log[gs], 3);
    check_val("t6_second", gnt_log[gs+1], 1);
    wait_drain(20);

    // Random request patterns, operands held per requester.
    for (int i = 0; i < NREQ; i++) set_op(i, 16'($urandom), 16'($urandom));
    for (int i = 0; i < 60; i++) begin
      req_valid = 4'($urandom);
      step(1);
    end
    req_valid = '0;
    wait_drain(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
